uart_reg_bank: RTL and testbench

//  Addressed bank of NUM_REGS UART control/status registers, each with a per-register access mode
//  (RW, RO, read-clear, write-1-to-clear sticky). One CPU port with byte enables and registered

---
 rtl/uart_reg_bank_pkg.sv | 26 ++
 rtl/uart_reg_cell.sv | 78 +++++++
 rtl/uart_reg_bank.sv | 113 +++++++++++
 tb/tb_uart_reg_bank.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_reg_bank_pkg.sv
// Shared definitions for the UART register bank: register access modes and
// the rule that resolves overlapping mode masks into one mode per register.
package uart_reg_bank_pkg;

    typedef enum logic [1:0] {
        MODE_RW  = 2'd0,
        MODE_RO  = 2'd1,
        MODE_RC  = 2'd2,
        MODE_W1C = 2'd3
    } reg_mode_e;

    // A register listed in several masks takes the strongest mode: RO > W1C > RC > RW.
    function automatic reg_mode_e mode_of(input logic ro, input logic rc, input logic w1c);
        if (ro) begin
            return MODE_RO;
        end
        if (w1c) begin
            return MODE_W1C;
        end
        if (rc) begin
            return MODE_RC;
        end
        return MODE_RW;
    endfunction

endpackage

// File: rtl/uart_reg_cell.sv
// One register of the UART bank together with its one-cycle update flag.
// The access mode is fixed at elaboration time by MODE.
module uart_reg_cell
    import uart_reg_bank_pkg::*;
#(
    parameter int        REG_WIDTH = 32,
    parameter reg_mode_e MODE      = MODE_RW
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cpu_wr_i,
    input  logic                   cpu_rd_i,
    input  logic [REG_WIDTH/8-1:0] cpu_be_i,
    input  logic [REG_WIDTH-1:0]   cpu_wdata_i,
    input  logic                   periph_wr_i,
    input  logic [REG_WIDTH-1:0]   periph_data_i,
    output logic [REG_WIDTH-1:0]   data_o,
    output logic                   updated_o
);

    logic [REG_WIDTH-1:0] data_q, data_d;
    logic                 updated_q, updated_d;
    logic [REG_WIDTH-1:0] be_mask;
    logic [REG_WIDTH-1:0] clr_bits;
    logic [REG_WIDTH-1:0] set_bits;
    logic                 rd_clear;

    for (genvar gi = 0; gi < REG_WIDTH / 8; gi++) begin : g_be
        assign be_mask[gi*8 +: 8] = {8{cpu_be_i[gi]}};
    end

    assign clr_bits = cpu_wr_i    ? (cpu_wdata_i & be_mask) : '0;
    assign set_bits = periph_wr_i ? periph_data_i           : '0;
    assign rd_clear = cpu_rd_i && (MODE == MODE_RC);

    always_comb begin
        data_d    = data_q;
        updated_d = 1'b0;
        case (MODE)
            MODE_W1C: begin
                // Set wins over clear on the same bit so no status event is lost.
                data_d    = (data_q & ~clr_bits) | set_bits;
                updated_d = periph_wr_i | (|(data_q & clr_bits));
            end
            MODE_RO: begin
                if (periph_wr_i) begin
                    data_d    = periph_data_i;
                    updated_d = 1'b1;
                end
            end
            default: begin
                if (cpu_wr_i) begin
                    data_d    = (data_q & ~be_mask) | (cpu_wdata_i & be_mask);
                    updated_d = 1'b1;
                end else if (periph_wr_i) begin
                    data_d    = periph_data_i;
                    updated_d = 1'b1;
                end else if (rd_clear) begin
                    data_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q    <= '0;
            updated_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            updated_q <= updated_d;
        end
    end

    assign data_o    = data_q;
    assign updated_o = updated_q;

endmodule

// File: rtl/uart_reg_bank.sv
// UART control/status register bank: CPU address decode, registered read port,
// error pulse, per-register cells and the sticky-status interrupt.
module uart_reg_bank
    import uart_reg_bank_pkg::*;
#(
    parameter int                  REG_WIDTH  = 32,
    parameter int                  NUM_REGS   = 8,
    parameter int                  ADDR_WIDTH = 3,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0] RC_MASK    = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK   = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [ADDR_WIDTH-1:0]         cpu_addr_i,
    input  logic                          cpu_wr_en_i,
    input  logic                          cpu_rd_en_i,
    input  logic [REG_WIDTH/8-1:0]        cpu_be_i,
    input  logic [REG_WIDTH-1:0]          cpu_wdata_i,
    output logic [REG_WIDTH-1:0]          cpu_rdata_o,
    output logic                          cpu_rvalid_o,
    output logic                          cpu_err_o,
    input  logic [NUM_REGS-1:0]           periph_wr_en_i,
    input  logic [NUM_REGS*REG_WIDTH-1:0] periph_data_i,
    output logic [NUM_REGS*REG_WIDTH-1:0] reg_data_o,
    output logic [NUM_REGS-1:0]           updated_o,
    output logic                          irq_o
);

    logic [NUM_REGS-1:0]  addr_sel;
    logic [NUM_REGS-1:0]  is_w1c;
    logic [REG_WIDTH-1:0] reg_arr [NUM_REGS];
    logic                 in_range;
    logic                 ro_hit;
    logic [REG_WIDTH-1:0] rd_mux;
    logic                 w1c_any;

    logic [REG_WIDTH-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 err_q, err_d;
    logic                 irq_q, irq_d;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        localparam reg_mode_e CellMode = mode_of(RO_MASK[gi], RC_MASK[gi], W1C_MASK[gi]);
        localparam logic [ADDR_WIDTH-1:0] CellAddr = ADDR_WIDTH'(gi);

        assign addr_sel[gi] = (cpu_addr_i == CellAddr);
        assign is_w1c[gi]   = (CellMode == MODE_W1C);

        uart_reg_cell #(
            .REG_WIDTH (REG_WIDTH),
            .MODE      (CellMode)
        ) u_cell (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .cpu_wr_i      (cpu_wr_en_i & addr_sel[gi]),
            .cpu_rd_i      (cpu_rd_en_i & addr_sel[gi]),
            .cpu_be_i      (cpu_be_i),
            .cpu_wdata_i   (cpu_wdata_i),
            .periph_wr_i   (periph_wr_en_i[gi]),
            .periph_data_i (periph_data_i[gi*REG_WIDTH +: REG_WIDTH]),
            .data_o        (reg_arr[gi]),
            .updated_o     (updated_o[gi])
        );

        assign reg_data_o[gi*REG_WIDTH +: REG_WIDTH] = reg_arr[gi];
    end

    // An address matches no cell exactly when it is at or beyond NUM_REGS.
    assign in_range = |addr_sel;
    assign ro_hit   = |(addr_sel & RO_MASK);

    always_comb begin
        rd_mux  = '0;
        w1c_any = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_sel[i]) begin
                rd_mux = reg_arr[i];
            end
            w1c_any = w1c_any | (is_w1c[i] & (|reg_arr[i]));
        end
    end

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = cpu_rd_en_i;
        err_d    = (cpu_rd_en_i & ~in_range) | (cpu_wr_en_i & (~in_range | ro_hit));
        irq_d    = w1c_any;
        if (cpu_rd_en_i) begin
            rdata_d = rd_mux;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
        end
    end

    assign cpu_rdata_o  = rdata_q;
    assign cpu_rvalid_o = rvalid_q;
    assign cpu_err_o    = err_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed bench for uart_reg_bank: six registers, reg2 RO, reg3 read-clear,
// reg4 sticky, the rest RW.
module tb_uart_reg_bank;

    localparam int RW = 32;
    localparam int NR = 6;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   cpu_addr;
    logic            cpu_wr_en;
    logic            cpu_rd_en;
    logic [RW/8-1:0] cpu_be;
    logic [RW-1:0]   cpu_wdata;
    logic [RW-1:0]   cpu_rdata;
    logic            cpu_rvalid;
    logic            cpu_err;
    logic [NR-1:0]   periph_wr_en;
    logic [NR*RW-1:0] periph_data;
    logic [NR*RW-1:0] reg_data;
    logic [NR-1:0]   updated;
    logic            irq;

    int errors = 0;
    int checks = 0;

    uart_reg_bank #(
        .REG_WIDTH  (RW),
        .NUM_REGS   (NR),
        .ADDR_WIDTH (AW),
        .RO_MASK    (6'b000100),
        .RC_MASK    (6'b001000),
        .W1C_MASK   (6'b010000)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cpu_addr_i     (cpu_addr),
        .cpu_wr_en_i    (cpu_wr_en),
        .cpu_rd_en_i    (cpu_rd_en),
        .cpu_be_i       (cpu_be),
        .cpu_wdata_i    (cpu_wdata),
        .cpu_rdata_o    (cpu_rdata),
        .cpu_rvalid_o   (cpu_rvalid),
        .cpu_err_o      (cpu_err),
        .periph_wr_en_i (periph_wr_en),
        .periph_data_i  (periph_data),
        .reg_data_o     (reg_data),
        .updated_o      (updated),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_addr     = '0;
        cpu_wr_en    = 1'b0;
        cpu_rd_en    = 1'b0;
        cpu_be       = '0;
        cpu_wdata    = '0;
        periph_wr_en = '0;
        periph_data  = '0;
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
        cpu_addr  = a;
        cpu_be    = be;
        cpu_wdata = d;
        cpu_wr_en = 1'b1;
    endtask

    task automatic cpu_rd(input logic [AW-1:0] a);
        cpu_addr  = a;
        cpu_rd_en = 1'b1;
    endtask

    task automatic p_wr(input int i, input logic [31:0] d);
        periph_wr_en[i]       = 1'b1;
        periph_data[i*RW +: RW] = d;
    endtask

    function automatic logic [31:0] reg_at(input int i);
        return reg_data[i*RW +: RW];
    endfunction

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", cpu_rdata, 32'h0);
        check("reset_rvalid", 32'(cpu_rvalid), 32'h0);
        check("reset_err", 32'(cpu_err), 32'h0);
        check("reset_updated", 32'(updated), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_regs_any", 32'(|reg_data), 32'h0);
        rst = 1'b0;
        tick();

        // RW byte-enable write
        p_wr(1, 32'h1122_3344);
        tick(); idle();
        check("rw_preload", reg_at(1), 32'h1122_3344);
        check("rw_preload_upd", 32'(updated), 32'h02);
        cpu_wr(3'd1, 4'b0101, 32'hAABB_CCDD);
        tick(); idle();
        check("rw_be_write", reg_at(1), 32'h11BB_33DD);
        check("rw_be_upd", 32'(updated), 32'h02);
        check("rw_be_err", 32'(cpu_err), 32'h0);
        tick();
        check("rw_upd_clears", 32'(updated), 32'h0);

        cpu_rd(3'd1);
        tick(); idle();
        check("rd1_rvalid", 32'(cpu_rvalid), 32'h1);
        check("rd1_rdata", cpu_rdata, 32'h11BB_33DD);
        tick();
        check("rd1_rvalid_drop", 32'(cpu_rvalid), 32'h0);
        check("rd1_rdata_hold", cpu_rdata, 32'h11BB_33DD);

        // RO register and out-of-range accesses
        p_wr(2, 32'hCAFE_0001);
        tick(); idle();
        check("ro_periph_write", reg_at(2), 32'hCAFE_0001);
        cpu_wr(3'd2, 4'b1111, 32'hFFFF_FFFF);
        tick(); idle();
        check("ro_cpu_ignored", reg_at(2), 32'hCAFE_0001);
        check("ro_err", 32'(cpu_err), 32'h1);
        check("ro_no_upd", 32'(updated), 32'h0);
        tick();
        check("ro_err_pulse", 32'(cpu_err), 32'h0);
        cpu_rd(3'd7);
        tick(); idle();
        check("oor_rd_rdata", cpu_rdata, 32'h0);
        check("oor_rd_rvalid", 32'(cpu_rvalid), 32'h1);
        check("oor_rd_err", 32'(cpu_err), 32'h1);
        cpu_wr(3'd6, 4'b1111, 32'hFFFF_FFFF);
        tick(); idle();
        check("oor_wr_err", 32'(cpu_err), 32'h1);
        check("oor_wr_no_upd", 32'(updated), 32'h0);
        check("oor_wr_reg5", reg_at(5), 32'h0);

        // Read-clear register
        p_wr(3, 32'h5A);
        tick(); idle();
        check("rc_preload", reg_at(3), 32'h5A);
        cpu_rd(3'd3);
        tick(); idle();
        check("rc_rdata", cpu_rdata, 32'h5A);
        check("rc_cleared", reg_at(3), 32'h0);
        check("rc_clear_no_upd", 32'(updated), 32'h0);
        p_wr(3, 32'h9);
        tick(); idle();
        cpu_rd(3'd3);
        p_wr(3, 32'h7);
        tick(); idle();
        check("rc_rd_old", cpu_rdata, 32'h9);
        check("rc_write_wins", reg_at(3), 32'h7);
        check("rc_write_upd", 32'(updated), 32'h08);

        // Sticky W1C register and interrupt
        p_wr(4, 32'h3);
        tick(); idle();
        check("w1c_set", reg_at(4), 32'h3);
        check("w1c_irq_lag", 32'(irq), 32'h0);
        tick();
        check("w1c_irq_on", 32'(irq), 32'h1);
        cpu_wr(3'd4, 4'b1111, 32'h1);
        p_wr(4, 32'h1);
        tick(); idle();
        check("w1c_collision", reg_at(4), 32'h3);
        check("w1c_coll_irq", 32'(irq), 32'h1);
        cpu_wr(3'd4, 4'b1111, 32'h3);
        tick(); idle();
        check("w1c_cleared", reg_at(4), 32'h0);
        check("w1c_irq_hold", 32'(irq), 32'h1);
        tick();
        check("w1c_irq_off", 32'(irq), 32'h0);

        // CPU and peripheral write the same RW register together
        cpu_wr(3'd0, 4'b1111, 32'h1);
        p_wr(0, 32'h2);
        tick(); idle();
        check("rw_cpu_wins", reg_at(0), 32'h1);
        check("rw_coll_upd", 32'(updated), 32'h01);
        tick();
        check("rw_coll_upd_pulse", 32'(updated), 32'h0);

        // Read and write in the same cycle
        cpu_wr(3'd0, 4'b1111, 32'h55);
        cpu_rd(3'd0);
        tick(); idle();
        check("rdwr_rdata_old", cpu_rdata, 32'h1);
        check("rdwr_reg_new", reg_at(0), 32'h55);

        // Asynchronous reset in the middle of accesses
        p_wr(4, 32'h8);
        tick(); idle();
        tick();
        check("pre_rst_irq", 32'(irq), 32'h1);
        cpu_rd(3'd2);
        tick(); idle();
        check("pre_rst_rvalid", 32'(cpu_rvalid), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_rvalid", 32'(cpu_rvalid), 32'h0);
        check("arst_rdata", cpu_rdata, 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        check("arst_reg2", reg_at(2), 32'h0);
        check("arst_regs_any", 32'(|reg_data), 32'h0);
        rst = 1'b0;
        tick();
        cpu_rd(3'd1);
        #3;
        rst = 1'b1;
        tick(); idle();
        check("arst_read_dropped", 32'(cpu_rvalid), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_rvalid", 32'(cpu_rvalid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
